uart_tx: RTL

Byte-wide UART transmitter, 8N1, LSB first. It sends bytes written by the Micro80 I/O side onto the serial `tx` line at the same fixed baud rate and clock as the receive path. A 4-entry FIFO decouples CPU write strobes from the line rate. A one-cycle `sent` pulse marks the end of each frame.

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx : byte-wide 8N1 UART transmitter, LSB first, with a 4-entry FIFO.
//
// Ports
//   clk   in   system clock, all state changes on the rising edge
//   nrst  in   asynchronous active-low reset
//   DIN   in   [7:0] byte to queue, sampled on a wr cycle
//   wr    in   write strobe, one byte per high cycle
//   tx    out  serial line, idle high, registered
//   busy  out  FIFO non-empty or a frame in progress
//   full  out  FIFO holds 4 bytes
//   sent  out  one-clock pulse after the stop bit of each frame completes
//
// A frame is start (ubrr clocks low), 8 data bits (ubrr clocks each),
// stop (ubrr clocks high) and one CLEANUP clock before returning to IDLE.

module uart_tx #(
    parameter int INCLOCK = 50000000,
    parameter int BAUDE   = 921600
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] DIN,
    input  logic       wr,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       sent
);

    localparam int          UBRR     = INCLOCK / BAUDE;
    localparam logic [14:0] BIT_LAST = 15'(UBRR - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_CLEANUP = 3'd4;

    logic [7:0]  r_fifo [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;

    logic [2:0]  r_state;
    logic [14:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_sent;

    logic        w_wrEn;
    logic        w_pop;
    logic        w_bitEnd;

    // Full is judged on the pre-edge count, so a write while full is dropped
    // even when the FSM pops in the same cycle.
    assign w_wrEn   = wr && (r_count != 3'd4);
    assign w_pop    = (r_state == S_IDLE) && (r_count != 3'd0);
    assign w_bitEnd = (r_cnt == BIT_LAST);

    assign tx   = r_tx;
    assign sent = r_sent;
    assign busy = (r_state != S_IDLE) || (r_count != 3'd0);
    assign full = (r_count == 3'd4);

    // FIFO storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_fifo[r_wptr] <= DIN;
        end
    end

    // Pointers wrap naturally in 2 bits; a simultaneous write and pop
    // leaves the count unchanged.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_wrEn) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_wrEn, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer. tx is registered so each level change lands exactly
    // on a bit-time boundary; sent is registered from CLEANUP so it rises
    // one clock after the stop bit finishes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= 15'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
            r_sent  <= 1'b0;
        end else begin
            r_sent <= (r_state == S_CLEANUP);
            case (r_state)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= 15'd0;
                    r_idx <= 3'd0;
                    if (r_count != 3'd0) begin
                        r_shift <= r_fifo[r_rptr];
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bitEnd) begin
                        r_cnt   <= 15'd0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                end
                S_DATA: begin
                    if (w_bitEnd) begin
                        r_cnt <= 15'd0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 3'd1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bitEnd) begin
                        r_cnt   <= 15'd0;
                        r_state <= S_CLEANUP;
                    end else begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                end
                S_CLEANUP: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
